// File: rtl/count_seq_checker_pkg.sv
// Shared definitions for the count sequence checker.
// Holds the checker state encoding and the default parameter values used by
// count_seq_checker and its testbench.
package count_seq_checker_pkg;

  // Checker states: HUNT waits for a first sample, SYNC builds up a run of
  // in-sequence samples, LOCKED checks every sample against the expected value.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_LOCK_CNT  = 2;
  localparam int DEF_ERR_CNT_W = 8;

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// sat_counter: saturating up-counter used for the checker's error tally.
// Ports:
//   clk    in   1      rising-edge clock
//   clr_n  in   1      asynchronous active-low clear
//   inc    in   1      add one this cycle (ignored once all-ones)
//   count  out  WIDTH  current count, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: receive-side monitor for a free-running up-counter.
// Locks onto the incoming count sequence, then checks each valid sample is
// the previous one plus one (mod 2^WIDTH). Mismatches pulse err_pulse and
// bump a saturating tally; a jump to zero while locked is a source restart.
//
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous active-low reset
//   cnt_in     in   WIDTH      observed count value
//   cnt_valid  in   1          cnt_in is sampled only when 1
//   locked     out  1          1 while in LOCKED
//   expected   out  WIDTH      next value the checker expects
//   err_pulse  out  1          one-cycle mismatch strobe
//   restart    out  1          one-cycle source-restart strobe
//   state_dbg  out  2          current FSM state (debug)
//   err_count  out  ERR_CNT_W  saturating mismatch total
// Optional (macro CNT_CHK_STICKY_EN):
//   err_clr    in   1          clears err_sticky
//   err_sticky out  1          set by any err_pulse; set wins over clear
//
// Handshake: a sample is taken on a rising edge where cnt_valid=1; there is no
// backpressure. All outputs are registered, so the reaction to a sample taken
// at edge N is visible just after edge N.
module count_seq_checker
  import count_seq_checker_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LOCK_CNT  = DEF_LOCK_CNT,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic                 cnt_valid,
  output logic                 locked,
  output logic [WIDTH-1:0]     expected,
  output logic                 err_pulse,
  output logic                 restart,
  output state_t               state_dbg,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef CNT_CHK_STICKY_EN
  ,
  input  logic                 err_clr,
  output logic                 err_sticky
`endif
);

  // run counts consecutive in-sequence samples (seed included) and only needs
  // to reach LOCK_CNT.
  localparam int RUN_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);
  // Where a fresh seed lands: straight into LOCKED when one sample suffices.
  localparam state_t SEED_ST = (LOCK_CNT == 1) ? ST_LOCKED : ST_SYNC;

  state_t           state, state_n;
  logic [WIDTH-1:0] exp_n;
  logic [RUN_W-1:0] run, run_n, run_inc;
  logic             err_n, restart_n;
  logic             match;

  assign match   = (cnt_in == expected);
  assign run_inc = run + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_HUNT;
      expected  <= '0;
      run       <= '0;
      err_pulse <= 1'b0;
      restart   <= 1'b0;
    end else begin
      state     <= state_n;
      expected  <= exp_n;
      run       <= run_n;
      err_pulse <= err_n;
      restart   <= restart_n;
    end
  end

  always_comb begin
    state_n   = state;
    exp_n     = expected;
    run_n     = run;
    err_n     = 1'b0;
    restart_n = 1'b0;
    if (cnt_valid) begin
      unique case (state)
        ST_HUNT: begin
          exp_n   = cnt_in + 1'b1;
          run_n   = RUN_W'(1);
          state_n = SEED_ST;
        end
        ST_SYNC: begin
          if (match) begin
            exp_n = expected + 1'b1;
            run_n = run_inc;
            if (run_inc >= LOCK_RUN) state_n = ST_LOCKED;
          end else begin
            // Not locked yet: reseed silently.
            exp_n = cnt_in + 1'b1;
            run_n = RUN_W'(1);
          end
        end
        ST_LOCKED: begin
          if (match) begin
            exp_n = expected + 1'b1;
          end else if (cnt_in == '0) begin
            // Counter restarted from zero: resync without counting an error.
            restart_n = 1'b1;
            exp_n     = WIDTH'(1);
          end else begin
            err_n   = 1'b1;
            exp_n   = cnt_in + 1'b1;
            run_n   = RUN_W'(1);
            state_n = SEED_ST;
          end
        end
        default: state_n = ST_HUNT;
      endcase
    end
  end

  assign locked    = (state == ST_LOCKED);
  assign state_dbg = state;

  // err_count advances on the same edge that raises err_pulse.
  sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (err_n),
    .count (err_count)
  );

`ifdef CNT_CHK_STICKY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_sticky <= 1'b0;
    else if (err_n)   err_sticky <= 1'b1;
    else if (err_clr) err_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Testbench for count_seq_checker. Two instances share the stimulus: one with
// default parameters and one with a 2-bit error counter to exercise saturation.
module tb_count_seq_checker;
  import count_seq_checker_pkg::*;

  localparam int W    = 4;
  localparam int LOCK = 2;
  localparam int MODV = 1 << W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] cnt_in = '0;
  logic         cnt_valid = 1'b0;
  logic         err_clr = 1'b0;

  logic         locked, err_pulse, restart;
  logic [W-1:0] expected;
  logic [7:0]   err_count;
  state_t       state_dbg;
  logic         locked_s, err_pulse_s, restart_s;
  logic [W-1:0] expected_s;
  logic [1:0]   err_count_s;
  state_t       state_dbg_s;
`ifdef CNT_CHK_STICKY_EN
  logic         err_sticky, err_sticky_s;
`endif

  count_seq_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .locked(locked), .expected(expected), .err_pulse(err_pulse),
    .restart(restart), .state_dbg(state_dbg), .err_count(err_count)
`ifdef CNT_CHK_STICKY_EN
    , .err_clr(err_clr), .err_sticky(err_sticky)
`endif
  );

  count_seq_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .locked(locked_s), .expected(expected_s), .err_pulse(err_pulse_s),
    .restart(restart_s), .state_dbg(state_dbg_s), .err_count(err_count_s)
`ifdef CNT_CHK_STICKY_EN
    , .err_clr(err_clr), .err_sticky(err_sticky_s)
`endif
  );

  // ---------------- reference model ----------------
  // Behavioural view: "have we seen anything", "are we locked", the value we
  // expect next, how long the current in-order run is, and the raw error total.
  bit m_seen, m_locked, m_errp, m_rst, m_sticky;
  int m_exp, m_run, m_err;

  function automatic void model_reset();
    m_seen = 0; m_locked = 0; m_errp = 0; m_rst = 0; m_sticky = 0;
    m_exp = 0; m_run = 0; m_err = 0;
  endfunction

  function automatic void model_seed(int v);
    m_seen   = 1;
    m_exp    = (v + 1) % MODV;
    m_run    = 1;
    m_locked = (LOCK == 1);
  endfunction

  function automatic void model_step(bit valid, int v, bit clr);
    m_errp = 0;
    m_rst  = 0;
    if (valid) begin
      if (!m_seen) begin
        model_seed(v);
      end else if (v == m_exp) begin
        m_exp = (m_exp + 1) % MODV;
        if (!m_locked) begin
          m_run++;
          if (m_run >= LOCK) m_locked = 1;
        end
      end else if (!m_locked) begin
        model_seed(v);
      end else if (v == 0) begin
        m_rst = 1;
        m_exp = 1;
      end else begin
        m_errp = 1;
        m_err++;
        model_seed(v);
      end
    end
    if (m_errp) m_sticky = 1;
    else if (clr) m_sticky = 0;
  endfunction

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ":locked"},      32'(locked),      32'(m_locked));
    check({tag, ":expected"},    32'(expected),    32'(m_exp));
    check({tag, ":err_pulse"},   32'(err_pulse),   32'(m_errp));
    check({tag, ":restart"},     32'(restart),     32'(m_rst));
    check({tag, ":err_count"},   32'(err_count),   32'(sat(m_err, 255)));
    check({tag, ":err_count_s"}, 32'(err_count_s), 32'(sat(m_err, 3)));
    check({tag, ":locked_s"},    32'(locked_s),    32'(m_locked));
    check({tag, ":expected_s"},  32'(expected_s),  32'(m_exp));
`ifdef CNT_CHK_STICKY_EN
    check({tag, ":err_sticky"},  32'(err_sticky),  32'(m_sticky));
`endif
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are checked 1ns after the rise.
  task automatic cycle(string tag, bit valid, int v, bit clr = 0);
    @(negedge clk);
    cnt_valid = valid;
    cnt_in    = W'(v);
    err_clr   = clr;
    @(posedge clk);
    model_step(valid, v, clr);
    #1;
    check_all(tag);
  endtask

  task automatic send(string tag, int v);
    cycle(tag, 1'b1, v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();

    // Reset held low for 20ns.
    #20;
    check_all("reset");
    check("reset:state", 32'(state_dbg), 32'(ST_HUNT));
    @(negedge clk);
    reset = 1'b1;

    // Lock on 3,4.
    send("lock0", 3);
    check("lock0:not_locked", 32'(locked), 32'd0);
    send("lock1", 4);
    check("lock1:locked", 32'(locked), 32'd1);
    check("lock1:exp5", 32'(expected), 32'd5);

    // Run through the wrap 15 -> 0 -> 1.
    for (int v = 5; v < 16; v++) send("run", v);
    send("wrap0", 0);
    send("wrap1", 1);
    check("wrap:exp2", 32'(expected), 32'd2);
    check("wrap:no_err", 32'(err_count), 32'd0);

    // Mismatch at expected=7: feed 9, then 10 relocks.
    for (int v = 2; v < 7; v++) send("pre_mm", v);
    check("mm:exp7", 32'(expected), 32'd7);
    send("mm9", 9);
    check("mm:err_pulse", 32'(err_pulse), 32'd1);
    check("mm:err_count1", 32'(err_count), 32'd1);
    check("mm:unlocked", 32'(locked), 32'd0);
    send("mm10", 10);
    check("mm:relocked", 32'(locked), 32'd1);
    check("mm:exp11", 32'(expected), 32'd11);
    check("mm:pulse_gone", 32'(err_pulse), 32'd0);

    // Restart at expected=9.
    for (int v = 11; v < 16; v++) send("pre_rs", v);
    for (int v = 0; v < 9; v++) send("pre_rs", v);
    check("rs:exp9", 32'(expected), 32'd9);
    send("rs0", 0);
    check("rs:restart", 32'(restart), 32'd1);
    check("rs:exp1", 32'(expected), 32'd1);
    check("rs:still_locked", 32'(locked), 32'd1);
    check("rs:err_same", 32'(err_count), 32'd1);

    // Five more errors, each followed by a relocking sample.
    for (int i = 0; i < 5; i++) begin
      int bad;
      bad = (m_exp + 3) % MODV;
      if (bad == 0) bad = 5;
      send("sat_bad", bad);
      send("sat_relock", (bad + 1) % MODV);
    end
    check("sat:err_count_s3", 32'(err_count_s), 32'd3);
    check("sat:err_count6", 32'(err_count), 32'd6);

    // Valid gap: random garbage on cnt_in must not disturb anything.
    for (int i = 0; i < 10; i++) cycle("gap", 1'b0, $urandom_range(0, MODV - 1));

`ifdef CNT_CHK_STICKY_EN
    check("sticky:held", 32'(err_sticky), 32'd1);
    cycle("sticky_clr", 1'b0, 0, 1'b1);
    check("sticky:cleared", 32'(err_sticky), 32'd0);
    // Same-cycle error and clear: set wins.
    send("sticky_pre", m_exp);
    cycle("sticky_both", 1'b1, (m_exp + 5) % MODV == 0 ? 3 : (m_exp + 5) % MODV, 1'b1);
    check("sticky:set_wins", 32'(err_sticky), 32'd1);
`endif

    // Randomized traffic, mostly in sequence with occasional gaps, zeros, jumps.
    for (int i = 0; i < 400; i++) begin
      int r, v;
      bit valid;
      valid = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)       v = m_exp;
      else if (r == 7) v = 0;
      else             v = $urandom_range(0, MODV - 1);
      cycle("rand", valid, v, ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("midreset");
    check("midreset:state", 32'(state_dbg), 32'(ST_HUNT));
    @(negedge clk);
    reset = 1'b1;
    send("post_reset0", 6);
    send("post_reset1", 7);
    check("post_reset:locked", 32'(locked), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
